irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Priority interrupt controller that sits directly upstream of the CPU core and drives its `irq` input. It synchronises up to eight asynchronous interrupt sources, latches rising edges as pending requests, and applies a software-programmable mask. It then raises a single request line and hands the CPU the winning vector on an acknowledge handshake. The controller is memory-mapped on the CPU's 16-bit address / 8-bit data bus, so firmware can read status, set masks and signal end-of-interrupt.

## Interface
Parameters:
- `N_SRC`, 8: number of interrupt sources (1..8).
- `BASE_ADDR`, 16'hFF00: base of the 4-byte register window.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `src`  in  N_SRC  raw asynchronous interrupt lines; rising edge requests service.
- `bus_addr`  in  16  CPU address.
- `bus_wdata`  in  8  CPU write data.
- `bus_we`  in  1  write strobe, single cycle.
- `bus_re`  in  1  read strobe.
- `bus_rdata`  out  8  read data; 0 when not selected.
- `irq`  out  1  interrupt request to CPU.
- `iack`  in  1  CPU acknowledge, single-cycle pulse.
- `vec`  out  3  index of the acknowledged source; valid from the cycle after `iack`.
- `in_service`  out  1  high while a handler is active.

## Operation
- **Register map** (offset from `BASE_ADDR`):
  - +0 PEND: read pending bits; write-1-to-clear.
  - +1 MASK: read/write; bit=1 enables the source.
  - +2 ISR: read-only one-hot in-service bit.
  - +3 EOI: any write ends service.
- Offsets +4 and above are not decoded. Bits at or above `N_SRC` read 0 and ignore writes.
- **Edge capture**: each `src[i]` passes through a 2-flop synchroniser, then rising-edge detection. A detected edge sets `PEND[i]`.
- **Pending-bit conflicts**:
  - Set and W1C clear in the same cycle: set wins.
  - Set and acknowledge-clear in the same cycle on the same bit: set wins, so the bit stays pending.
- **Priority**: lowest index wins among `PEND & MASK`.
- **FSM states**: IDLE, REQ, SERVICE.
  - IDLE -> REQ when `PEND & MASK` is nonzero.
  - REQ -> SERVICE on `iack`:
    - latch `vec` = winning index;
    - clear that `PEND` bit;
    - set the matching ISR bit.
  - REQ -> IDLE if `PEND & MASK` becomes zero before `iack` (mask write or W1C). `iack` in that same cycle is ignored.
  - SERVICE -> IDLE on an EOI write; ISR clears.
  - `iack` in IDLE or SERVICE is ignored. `vec` holds its last value.
  - EOI in IDLE or REQ is ignored.
- **No nesting**: new edges accumulate in PEND during SERVICE. PEND bits are sticky, so multiple edges on one source while pending collapse to one request.
- **Outputs**: `irq` = (state==REQ), registered. `in_service` = (state==SERVICE).
- **Mid-operation reset**: `rst` in any state returns the block to IDLE and clears everything, including synchroniser flops.

## Timing
- **Reset values**:
  - `irq`=0, `vec`=0, `in_service`=0, `bus_rdata`=0.
  - PEND=0, MASK=0, ISR=0, all synchroniser flops 0, state IDLE.
- **Edge-to-irq latency** (source enabled, FSM idle), with `src` rising before edge E0:
  - s1=1 after E0;
  - s2=1 after E1;
  - PEND=1 after E2;
  - `irq`=1 after E3.
- **Acknowledge**: `iack` sampled at edge Ek gives `irq`=0, `vec` valid and `in_service`=1 after Ek.
- **EOI**: an EOI write at edge Em gives `in_service`=0 after Em. If another enabled request is pending, `irq`=1 after Em+1.
- **Bus read**: combinational in the same cycle as `bus_re`.
- **Bus write**: takes effect at the next edge. A MASK write affects the FSM from the following cycle.

## Structure
- Shared package `cpu16_pkg`:
  - register offsets IRQ_PEND, IRQ_MASK, IRQ_ISR, IRQ_EOI;
  - FSM state enum {IDLE, REQ, SERVICE};
  - `N_IRQ_MAX`=8.
- Sub-module `sync_edge`: 2-flop synchroniser plus rising-edge pulse, with the same `clk`/`rst`. Instantiated once per source via generate.
- Priority encoder, register file and FSM live in `irq_ctrl`.

## Test plan
- **Reset**: assert `rst` with `src`=8'hFF. Release `rst`, hold `src`=8'hFF, MASK=0 → PEND=8'h00 (no edge), `irq`=0, all reads 0.
- **Single source**: MASK=8'h10, pulse `src[4]` → `irq`=1 exactly 4 edges later; `iack` → `vec`=4, PEND[4]=0, ISR=8'h10; EOI → `in_service`=0.
- **Priority and queueing**: MASK=8'hFF, raise `src[6]` and `src[2]` together → `vec`=2. During SERVICE, pulse `src[6]` again → PEND stays 8'h40. After EOI, `irq` returns and `iack` gives `vec`=6.
- **Mask and withdraw**: PEND=8'h01 with `irq`=1; write MASK=0 → `irq`=0 next cycle, PEND still 8'h01. Re-enable → `irq` returns.
- **Conflicts**: W1C of PEND bit 3 in the same cycle as a new edge on `src[3]` → PEND[3]=1. `iack` issued in IDLE → ignored, `vec` unchanged.
- **Mid-service reset**: `rst` during SERVICE → `in_service`=0 and ISR=0 next cycle; no spurious `irq`.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared definitions for the cpu16 peripheral slice: interrupt controller
// register offsets, controller state encoding and a priority helper.
package cpu16_pkg;

  // Widest interrupt vector the controller supports (3-bit vec).
  localparam int N_IRQ_MAX = 8;

  // Register offsets inside the 4-byte interrupt controller window.
  localparam logic [1:0] IRQ_PEND = 2'd0;
  localparam logic [1:0] IRQ_MASK = 2'd1;
  localparam logic [1:0] IRQ_ISR  = 2'd2;
  localparam logic [1:0] IRQ_EOI  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Index of the lowest set bit (lowest index has highest priority).
  // Returns 0 for an all-zero vector; callers only use it when nonzero.
  function automatic logic [2:0] lowest_set(input logic [N_IRQ_MAX-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_IRQ_MAX - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line followed by a
// rising-edge detector. The pulse is held off for the first cycles after
// reset so that a line already high when reset releases is treated as a
// level, not as a new request.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  output logic pulse_o
);

  logic       s1_q;
  logic       s2_q;
  logic       prev_q;
  logic [1:0] warm_q;

  // Synchroniser chain, edge reference flop and post-reset warm-up counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      warm_q <= 2'd0;
    end else begin
      s1_q   <= a_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  // Edge is only trusted once the reference flop holds a real sample.
  assign pulse_o = s2_q & ~prev_q & (warm_q == 2'd3);

endmodule

// File: rtl/irq_ctrl.sv
// Priority interrupt controller: per-source edge capture into PEND,
// software mask, lowest-index-wins arbitration and an IDLE/REQ/SERVICE
// handshake with the CPU, all behind a 4-byte memory-mapped window.
module irq_ctrl
  import cpu16_pkg::*;
#(
  parameter int          N_SRC     = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic [15:0]      bus_addr,
  input  logic [7:0]       bus_wdata,
  input  logic             bus_we,
  input  logic             bus_re,
  output logic [7:0]       bus_rdata,
  output logic             irq,
  input  logic             iack,
  output logic [2:0]       vec,
  output logic             in_service
);

  irq_state_e state_q, state_d;

  logic [N_SRC-1:0]     pend_q, pend_d;
  logic [N_SRC-1:0]     mask_q, mask_d;
  logic [N_SRC-1:0]     isr_q, isr_d;
  logic [2:0]           vec_q, vec_d;

  logic [N_SRC-1:0]     edge_s;
  logic [N_SRC-1:0]     req_s;
  logic [N_SRC-1:0]     w1c_s;
  logic [N_SRC-1:0]     ack_clr_s;
  logic [N_SRC-1:0]     win_oh_s;
  logic [N_IRQ_MAX-1:0] req_w_s;
  logic [N_IRQ_MAX-1:0] win_oh_w_s;
  logic [7:0]           rdata_s;
  logic [2:0]           win_s;
  logic [1:0]           off_s;
  logic                 sel_s;
  logic                 wr_pend_s;
  logic                 wr_mask_s;
  logic                 wr_eoi_s;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .a_i     (src[i]),
      .pulse_o (edge_s[i])
    );
  end

  // Window decode: only the four word-aligned offsets are claimed.
  assign sel_s     = (bus_addr[15:2] == BASE_ADDR[15:2]);
  assign off_s     = bus_addr[1:0];
  assign wr_pend_s = bus_we & sel_s & (off_s == IRQ_PEND);
  assign wr_mask_s = bus_we & sel_s & (off_s == IRQ_MASK);
  assign wr_eoi_s  = bus_we & sel_s & (off_s == IRQ_EOI);

  assign req_s = pend_q & mask_q;

  // Widen the request vector to the helper's fixed width.
  always_comb begin
    req_w_s = {N_IRQ_MAX{1'b0}};
    req_w_s[N_SRC-1:0] = req_s;
  end

  assign win_s      = lowest_set(req_w_s);
  assign win_oh_w_s = {{(N_IRQ_MAX-1){1'b0}}, 1'b1} << win_s;
  assign win_oh_s   = win_oh_w_s[N_SRC-1:0];

  // Software write strobes for PEND (W1C) and MASK.
  always_comb begin
    if (wr_pend_s) begin
      w1c_s = bus_wdata[N_SRC-1:0];
    end else begin
      w1c_s = {N_SRC{1'b0}};
    end
    if (wr_mask_s) begin
      mask_d = bus_wdata[N_SRC-1:0];
    end else begin
      mask_d = mask_q;
    end
  end

  // Handshake FSM: next state, vector latch, ISR and acknowledge clear.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    isr_d     = isr_q;
    ack_clr_s = {N_SRC{1'b0}};
    case (state_q)
      IDLE: begin
        if (|req_s) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // Withdrawal takes precedence: an iack against nothing is dropped.
        if (!(|req_s)) begin
          state_d = IDLE;
        end else if (iack) begin
          state_d   = SERVICE;
          vec_d     = win_s;
          isr_d     = win_oh_s;
          ack_clr_s = win_oh_s;
        end else begin
          state_d = REQ;
        end
      end
      SERVICE: begin
        if (wr_eoi_s) begin
          state_d = IDLE;
          isr_d   = {N_SRC{1'b0}};
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d = IDLE;
        isr_d   = {N_SRC{1'b0}};
      end
    endcase
  end

  // New edges are OR'd in last so a set beats any clear in the same cycle.
  assign pend_d = (pend_q & ~w1c_s & ~ack_clr_s) | edge_s;

  // Controller state and register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= {N_SRC{1'b0}};
      mask_q  <= {N_SRC{1'b0}};
      isr_q   <= {N_SRC{1'b0}};
      vec_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      isr_q   <= isr_d;
      vec_q   <= vec_d;
    end
  end

  // Combinational read-back; unselected or unread cycles return zero.
  always_comb begin
    rdata_s = 8'h00;
    if (bus_re && sel_s) begin
      case (off_s)
        IRQ_PEND: rdata_s[N_SRC-1:0] = pend_q;
        IRQ_MASK: rdata_s[N_SRC-1:0] = mask_q;
        IRQ_ISR:  rdata_s[N_SRC-1:0] = isr_q;
        default:  rdata_s = 8'h00;
      endcase
    end else begin
      rdata_s = 8'h00;
    end
  end

  assign bus_rdata  = rdata_s;
  assign irq        = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign vec        = vec_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with a cycle-level behavioural model that is
// checked against the DUT outputs after every clock edge.
module tb_irq_ctrl;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [7:0]  bus_rdata;
  logic        irq;
  logic        iack;
  logic [2:0]  vec;
  logic        in_service;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: pending/mask/ISR as integers, handler status as flags.
  int m_pend, m_mask, m_isr, m_vec;
  bit m_irq, m_svc;
  int hist [3];
  int nsamp;

  always #5 clk = ~clk;

  irq_ctrl #(.N_SRC(8), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .irq        (irq),
    .iack       (iack),
    .vec        (vec),
    .in_service (in_service)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lowest(input int v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int model_read(input int off);
    case (off)
      0:       return m_pend;
      1:       return m_mask;
      2:       return m_isr;
      default: return 0;
    endcase
  endfunction

  // One clock edge of the model. Sample s[n] is src at post-reset edge n;
  // PEND sets at edge n when s[n-2]=1 and s[n-3]=0 (both taken after reset).
  task automatic model_step();
    int  req, set, clr, w1c, off;
    bit  sel;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_isr = 0; m_vec = 0;
      m_irq = 1'b0; m_svc = 1'b0;
      hist[0] = 0; hist[1] = 0; hist[2] = 0; nsamp = 0;
    end else begin
      sel = ((int'(bus_addr) / 4) == (int'(BASE) / 4));
      off = int'(bus_addr) % 4;
      set = (nsamp >= 3) ? (hist[1] & ~hist[2] & 255) : 0;
      req = m_pend & m_mask;
      clr = 0;
      w1c = (bus_we && sel && off == 0) ? int'(bus_wdata) : 0;
      if (m_svc) begin
        if (bus_we && sel && off == 3) begin
          m_svc = 1'b0;
          m_isr = 0;
        end
      end else if (m_irq) begin
        if (req == 0) m_irq = 1'b0;
        else if (iack) begin
          m_vec = lowest(req);
          clr   = 1 << m_vec;
          m_isr = clr;
          m_irq = 1'b0;
          m_svc = 1'b1;
        end
      end else if (req != 0) begin
        m_irq = 1'b1;
      end
      m_pend = ((m_pend & ~w1c & ~clr) | set) & 255;
      if (bus_we && sel && off == 1) m_mask = int'(bus_wdata);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = int'(src);
      if (nsamp < 3) nsamp++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Continuous compare of the registered outputs against the model.
  initial forever begin
    @(posedge clk);
    #1;
    check("cyc_irq", int'(irq), int'(m_irq));
    check("cyc_in_service", int'(in_service), int'(m_svc));
    check("cyc_vec", int'(vec), m_vec);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int off, input int data);
    bus_addr  = BASE + 16'(off);
    bus_wdata = 8'(data);
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic rd(input int off, input int exp, input string name);
    bus_addr = BASE + 16'(off);
    bus_re   = 1'b1;
    #1;
    check(name, int'(bus_rdata), exp);
    check({name, "_model"}, int'(bus_rdata), model_read(off));
    bus_re   = 1'b0;
  endtask

  task automatic ack();
    iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int max);
    int k;
    k = 0;
    while (!irq && k < max) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(irq), 1);
  endtask

  initial begin
    rst = 1'b1; src = 8'hFF; bus_addr = 16'h0000; bus_wdata = 8'h00;
    bus_we = 1'b0; bus_re = 1'b0; iack = 1'b0;

    // Reset with all sources high: nothing pending afterwards.
    tick(3);
    check("rst_irq", int'(irq), 0);
    check("rst_vec", int'(vec), 0);
    check("rst_in_service", int'(in_service), 0);
    check("rst_rdata_idle", int'(bus_rdata), 0);
    rst = 1'b0;
    tick(6);
    rd(0, 8'h00, "rst_pend");
    rd(1, 8'h00, "rst_mask");
    rd(2, 8'h00, "rst_isr");
    rd(3, 8'h00, "rst_eoi_rd");
    rd(4, 8'h00, "undecoded_rd");
    check("rst_irq_after", int'(irq), 0);

    // Single source with exact latency.
    src = 8'h00; tick(3);
    wr(1, 8'h10); tick(2);
    src = 8'h10;
    tick(1); check("lat_e0", int'(irq), 0);
    tick(1); check("lat_e1", int'(irq), 0);
    tick(1); check("lat_e2", int'(irq), 0);
    rd(0, 8'h10, "lat_pend");
    tick(1); check("lat_e3", int'(irq), 1);
    src = 8'h00;
    ack();
    check("s_ack_irq", int'(irq), 0);
    check("s_vec", int'(vec), 4);
    check("s_in_service", int'(in_service), 1);
    rd(0, 8'h00, "s_pend");
    rd(2, 8'h10, "s_isr");
    wr(3, 8'h00);
    check("s_eoi", int'(in_service), 0);
    rd(2, 8'h00, "s_isr_clr");

    // Priority and queueing.
    wr(1, 8'hFF);
    src = 8'h44;
    wait_irq("p_irq", 8);
    ack();
    check("p_vec2", int'(vec), 2);
    rd(0, 8'h40, "p_pend");
    rd(2, 8'h04, "p_isr");
    src = 8'h00; tick(3);
    src = 8'h40; tick(4);
    rd(0, 8'h40, "p_pend_sticky");
    check("p_no_nest", int'(irq), 0);
    wr(3, 8'h00);
    check("p_eoi_svc", int'(in_service), 0);
    check("p_eoi_irq0", int'(irq), 0);
    tick(1);
    check("p_eoi_irq1", int'(irq), 1);
    ack();
    check("p_vec6", int'(vec), 6);
    wr(3, 8'h00);
    src = 8'h00;

    // Mask and withdraw.
    src = 8'h01;
    wait_irq("m_irq", 8);
    rd(0, 8'h01, "m_pend");
    wr(1, 8'h00);
    tick(1);
    check("m_withdraw", int'(irq), 0);
    rd(0, 8'h01, "m_pend_kept");
    wr(1, 8'h01);
    tick(1);
    check("m_reenable", int'(irq), 1);
    ack();
    check("m_vec0", int'(vec), 0);
    wr(3, 8'h00);
    src = 8'h00;

    // Set beats W1C on the same bit.
    wr(1, 8'h00);
    src = 8'h08; tick(4);
    src = 8'h00; tick(3);
    rd(0, 8'h08, "c_pend_pre");
    src = 8'h08;
    tick(2);
    wr(0, 8'h08);
    rd(0, 8'h08, "c_set_wins_w1c");
    src = 8'h00; tick(3);
    wr(0, 8'h08);
    rd(0, 8'h00, "c_w1c");

    // iack while idle is ignored.
    src = 8'h08; tick(4);
    ack();
    check("c_idle_iack_vec", int'(vec), 0);
    check("c_idle_iack_svc", int'(in_service), 0);
    wr(0, 8'h08);
    src = 8'h00;

    // Set beats acknowledge-clear on the same bit.
    wr(1, 8'h20);
    src = 8'h20;
    wait_irq("a_irq", 8);
    src = 8'h00; tick(3);
    src = 8'h20;
    tick(2);
    ack();
    check("a_vec5", int'(vec), 5);
    rd(0, 8'h20, "a_set_wins_ack");
    rd(2, 8'h20, "a_isr");
    wr(3, 8'h00);
    tick(1);
    check("a_irq_again", int'(irq), 1);
    ack();
    wr(3, 8'h00);
    src = 8'h00;
    rd(0, 8'h00, "a_pend_clr");

    // Reset in the middle of service.
    wr(1, 8'h02);
    src = 8'h02;
    wait_irq("r_irq", 8);
    ack();
    check("r_in_service", int'(in_service), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("r_svc_clr", int'(in_service), 0);
    check("r_vec_clr", int'(vec), 0);
    rd(2, 8'h00, "r_isr");
    rd(1, 8'h00, "r_mask");
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("r_no_irq", int'(irq), 0);
    end
    rd(0, 8'h00, "r_pend");
    src = 8'h00;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
